// File: rtl/jtag_cmd_master.sv
// jtag_cmd_master
// Turns one host command (memory write/read, register write, status read)
// into a complete virtual-JTAG transaction on the target side:
//   IDLE -> UIR -> CDR -> SDR (N bits) -> UDR -> RESP -> IDLE
// Every UIR/CDR/UDR state and every SDR bit lasts one tck period: TCK_HALF
// clk cycles with tck low, then TCK_HALF clk cycles with tck high. tdi,
// ir_in and the v_* strobes only change on the clk edge that drives tck low,
// so they are stable around every tck rising edge.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so one command is
// in flight at a time. rsp_valid is a one-cycle pulse with no back-pressure;
// rsp_data stays valid until the next response pulse.
module jtag_cmd_master #(
  parameter int unsigned TCK_HALF = 1  // clk cycles per tck half-period, 1..255
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tdi,
  input  logic        tdo,
  output logic [2:0]  ir_in,
  output logic        v_uir,
  output logic        v_cdr,
  output logic        v_sdr,
  output logic        v_udr,
  output logic [2:0]  fsm_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  // Command opcodes
  localparam logic [1:0] OP_MEM_WRITE   = 2'd0;
  localparam logic [1:0] OP_MEM_READ    = 2'd1;
  localparam logic [1:0] OP_REG_WRITE   = 2'd2;
  localparam logic [1:0] OP_STATUS_READ = 2'd3;

  // Virtual instruction codes presented on ir_in
  localparam logic [2:0] IR_MEM_WRITE = 3'b011;
  localparam logic [2:0] IR_MEM_READ  = 3'b010;
  localparam logic [2:0] IR_REG       = 3'b001;

  // Last index of the half-period counter; counter stops here, never wraps.
  localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);

  // Last SDR bit index for 24-bit (memory) and 16-bit (register) shifts.
  localparam logic [4:0] LAST_BIT_MEM = 5'd23;
  localparam logic [4:0] LAST_BIT_REG = 5'd15;

  // Number of tdo samples that make up the response byte.
  localparam logic [4:0] CAP_BITS = 5'd8;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [7:0]  half_cnt;
  logic [4:0]  bit_cnt;
  logic [1:0]  op_q;
  logic [23:0] word_q;
  logic [23:0] word_new;
  logic [2:0]  ir_new;
  logic [7:0]  cap_q;
  logic [4:0]  last_idx;

  logic accept;
  logic in_phase;
  logic half_done;
  logic tck_rise;
  logic period_end;
  logic last_bit;

  assign accept     = cmd_valid && (state == S_IDLE);
  assign in_phase   = (state == S_UIR) || (state == S_CDR) ||
                      (state == S_SDR) || (state == S_UDR);
  assign half_done  = (half_cnt == HALF_LAST);
  assign tck_rise   = in_phase && half_done && !tck;
  assign period_end = in_phase && half_done && tck;
  // Memory ops (op[1]==0) shift 24 bits, register/status ops shift 16.
  assign last_idx   = op_q[1] ? LAST_BIT_REG : LAST_BIT_MEM;
  assign last_bit   = (bit_cnt == last_idx);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Shift word and instruction code derived from the incoming command.
  // Register/status words are 16 bits, kept in the low half of the 24-bit
  // holding register.
  always_comb begin
    word_new = 24'h000000;
    ir_new   = IR_REG;
    case (cmd_op)
      OP_MEM_WRITE: begin
        word_new = {cmd_addr, cmd_data};
        ir_new   = IR_MEM_WRITE;
      end
      OP_MEM_READ: begin
        word_new = {cmd_addr, 8'h00};
        ir_new   = IR_MEM_READ;
      end
      OP_REG_WRITE: begin
        word_new = {8'h00, 4'h0, cmd_addr[3:0], cmd_data};
        ir_new   = IR_REG;
      end
      OP_STATUS_READ: begin
        word_new = {8'h00, 16'h0F00};
        ir_new   = IR_REG;
      end
      default: begin
        word_new = 24'h000000;
        ir_new   = IR_REG;
      end
    endcase
  end

  // Next-state logic: each JTAG phase advances at the end of its tck period.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_UIR;
      S_UIR:  if (period_end) state_nxt = S_CDR;
      S_CDR:  if (period_end) state_nxt = S_SDR;
      S_SDR:  if (period_end && last_bit) state_nxt = S_UDR;
      S_UDR:  if (period_end) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Half-period counter: counts clk cycles within a tck half, restarts at
  // every tck edge and stays at zero outside the shifting phases.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)                           half_cnt <= 8'd0;
    else if (accept || !in_phase)        half_cnt <= 8'd0;
    else if (half_done)                  half_cnt <= 8'd0;
    else                                 half_cnt <= half_cnt + 8'd1;
  end

  // tck generation: high for the second half of each period, low elsewhere.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)            tck <= 1'b0;
    else if (tck_rise)    tck <= 1'b1;
    else if (period_end)  tck <= 1'b0;
    else if (!in_phase)   tck <= 1'b0;
  end

  // Command capture at acceptance; the shift word moves right one bit at
  // the end of every SDR bit except the last.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      op_q   <= 2'd0;
      word_q <= 24'h000000;
    end else if (accept) begin
      op_q   <= cmd_op;
      word_q <= word_new;
    end else if ((state == S_SDR) && period_end && !last_bit) begin
      word_q <= {1'b0, word_q[23:1]};
    end
  end

  // SDR bit counter; it stops at the last bit, where the FSM leaves SDR.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)                                           bit_cnt <= 5'd0;
    else if (accept)                                     bit_cnt <= 5'd0;
    else if ((state == S_SDR) && period_end && !last_bit) bit_cnt <= bit_cnt + 5'd1;
  end

  // tdi: LSB of the shift word first, updated only on tck-low edges.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      tdi <= 1'b0;
    end else if (accept) begin
      tdi <= 1'b0;
    end else if (period_end) begin
      if (state == S_CDR)                  tdi <= word_q[0];
      else if ((state == S_SDR) && !last_bit) tdi <= word_q[1];
      else                                 tdi <= 1'b0;
    end
  end

  // Instruction register: loaded at the start of UIR, held until the next.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)       ir_in <= 3'b000;
    else if (accept) ir_in <= ir_new;
  end

  // Phase strobes: exactly one high per phase, handed over on tck-low edges.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      v_uir <= 1'b0;
      v_cdr <= 1'b0;
      v_sdr <= 1'b0;
      v_udr <= 1'b0;
    end else if (accept) begin
      v_uir <= 1'b1;
      v_cdr <= 1'b0;
      v_sdr <= 1'b0;
      v_udr <= 1'b0;
    end else if (period_end) begin
      case (state)
        S_UIR: begin
          v_uir <= 1'b0;
          v_cdr <= 1'b1;
        end
        S_CDR: begin
          v_cdr <= 1'b0;
          v_sdr <= 1'b1;
        end
        S_SDR: begin
          if (last_bit) begin
            v_sdr <= 1'b0;
            v_udr <= 1'b1;
          end
        end
        S_UDR: begin
          v_udr <= 1'b0;
        end
        default: begin
          v_uir <= 1'b0;
          v_cdr <= 1'b0;
          v_sdr <= 1'b0;
          v_udr <= 1'b0;
        end
      endcase
    end
  end

  // tdo capture: sampled as tck rises in the first eight SDR bits, bit 0
  // first, so after eight shifts the first sample sits in bit 0.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      cap_q <= 8'h00;
    end else if (accept) begin
      cap_q <= 8'h00;
    end else if ((state == S_SDR) && tck_rise && (bit_cnt < CAP_BITS)) begin
      cap_q <= {tdo, cap_q[7:1]};
    end
  end

  // Response: one-cycle pulse in RESP, data held until the next response.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= (state == S_UDR) && period_end;
      if ((state == S_UDR) && period_end) rsp_data <= cap_q;
    end
  end

endmodule

// File: doc/jtag_cmd_master.md
JTAG_CMD_MASTER -- requirements
Module: jtag_cmd_master

Interface
REQ-001 SHALL have parameter TCK_HALF, default 1, meaning clk cycles per tck half-period (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port aclr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake, transfer when both high on a clk edge.
REQ-005 SHALL have port cmd_op  input  2  with 0=MEM_WRITE, 1=MEM_READ, 2=REG_WRITE, 3=STATUS_READ.
REQ-006 SHALL have ports cmd_addr input 16 (memory address; REG_WRITE uses [3:0]) and cmd_data input 8 (write byte).
REQ-007 SHALL have ports rsp_valid output 1 (one-cycle completion pulse), rsp_data output 8 (captured byte) and busy output 1.
REQ-008 SHALL have ports tck output 1, tdi output 1, tdo input 1, ir_in output 3, v_uir, v_cdr, v_sdr, v_udr outputs 1 each (virtual-JTAG target side).

Function
REQ-009 SHALL latch cmd_op/addr/data at acceptance; later input changes ignored until the next acceptance.
REQ-010 SHALL assert cmd_ready only in IDLE; busy = not IDLE.
REQ-011 SHALL run FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE.
REQ-012 Each UIR, CDR, UDR state and each SDR bit SHALL be one tck period: TCK_HALF clk with tck=0, then TCK_HALF clk with tck=1; tck=0 in IDLE and RESP.
REQ-013 Outputs tdi, ir_in and v_* SHALL change only on the clk edge that drives tck low, i.e. stable across every tck rising edge.
REQ-014 ir_in SHALL be loaded at UIR start: MEM_WRITE->3'b011, MEM_READ->3'b010, REG_WRITE and STATUS_READ->3'b001; held until the next UIR.
REQ-015 v_uir high for the UIR tck period only; v_cdr for CDR only; v_sdr for all SDR bits; v_udr for UDR only; never two v_* high together.
REQ-016 Shift length N SHALL be 24 for MEM_WRITE/MEM_READ and 16 for REG_WRITE/STATUS_READ.
REQ-017 Shift word SHALL be {addr,data} for MEM_WRITE, {addr,8'h00} for MEM_READ, {4'h0,addr[3:0],data} for REG_WRITE, and 16'h0F00 for STATUS_READ.
REQ-018 tdi SHALL present the shift word LSB first, one bit per SDR tck period.
REQ-019 tdo SHALL be sampled on the clk edge that drives tck high in each SDR bit; the first 8 samples form rsp_data, bit 0 first.
REQ-020 STATUS_READ SHALL return rsp_data[0]=target busy and rsp_data[1]=target done; register 0xF receiving 0x00 is its defined side effect.
REQ-021 MEM_WRITE with addr >= 16'hFFF0 SHALL pass through unchanged; the target handles the register alias.
REQ-022 RESP SHALL last one clk with rsp_valid=1; rsp_data holds its value until the next RESP.
REQ-023 Latency: rsp_valid high exactly 2*TCK_HALF*(N+3)+1 clk after the acceptance edge.
REQ-024 cmd_valid during RESP SHALL NOT be accepted; it is accepted in the following IDLE cycle, giving back-to-back spacing of 2*TCK_HALF*(N+3)+2 clk.
REQ-025 Bit counter and half-period counter SHALL NOT wrap; SDR exits after exactly N bits.

Reset
REQ-026 aclr low SHALL immediately force IDLE, tck=0, tdi=0, ir_in=3'b000, all v_*=0, rsp_valid=0, rsp_data=8'h00, busy=0, and cmd_ready=1 after release.
REQ-027 aclr asserted mid-command SHALL abort it with no rsp_valid; the first command after release starts a fresh UIR.

Verification
REQ-028 MEM_WRITE addr=0x0010 data=0xA5, TCK_HALF=1 -> ir_in=3'b011, tdi sequence 0xA5 then 0x0010 LSB first, 24 v_sdr periods, one v_udr, rsp_valid at clk 55.
REQ-029 MEM_READ addr=0x1234, target memory holds 0x3C -> rsp_data=0x3C at clk 55, ir_in=3'b010.
REQ-030 REG_WRITE addr=0x6 data=0x01 -> 16 tdi bits form 0x0601, rsp_valid at clk 39, target start level high.
REQ-031 STATUS_READ with target busy=1, done=0 -> rsp_data=0x01; with busy=0, done=1 -> rsp_data=0x02.
REQ-032 aclr pulsed during SDR bit 10 of MEM_WRITE -> all outputs at reset values, no rsp_valid, target UDR never pulses; next command completes normally.
REQ-033 cmd_valid held high for two commands with TCK_HALF=3 -> each tck half-period 3 clk, second acceptance 1 clk after first rsp_valid, no overlap of v_* pulses.
